pipe_hazard_ctrl: RTL

Central sequencer for the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC of the 5-stage core. It drives every pipe EN/flush pair and pc_en from cache hit status, load-use hazards, taken branches from EX, and the halt flag as it moves down the pipe. A small FSM tracks data-memory waits, halt drain and the final halted state.

---
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequences the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB
// pipeline registers from cache hits, load-use hazards, taken branches and
// the halt flag as it travels down the pipe.
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int REGW = 5
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            mem_dREN,
  input  logic            mem_dWEN,
  input  logic            ex_dREN,
  input  logic [REGW-1:0] ex_wsel,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic            ex_branch_taken,
  input  logic            ex_halt,
  input  logic            wb_halt,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_en,
  output logic            idex_flush,
  output logic            exmem_en,
  output logic            exmem_flush,
  output logic            memwb_en,
  output logic            memwb_flush,
  output logic            halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALT} state_t;

  state_t state, state_nxt;
  logic   mem_busy;
  logic   lu_haz;
  logic   freeze;
  logic   drain_now;

  assign mem_busy = (mem_dREN | mem_dWEN) & ~dhit;
  assign lu_haz   = ex_dREN & (ex_wsel != '0) &
                    ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

  // State register; reset always lands in RUN.
  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state and all pipe controls; the ex_halt cycle already drains the front end.
  always_comb begin
    state_nxt   = state;
    freeze      = 1'b0;
    drain_now   = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    if (RST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_nxt   = RUN;
    end else if (state == HALT) begin
      halted = 1'b1;
    end else begin
      freeze    = (state == DWAIT) ? ~dhit : mem_busy;
      drain_now = (state == DRAIN) | ex_halt;
      if (!freeze) begin
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        if (ex_branch_taken && !drain_now) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (lu_haz) begin
          idex_flush = 1'b1;
        end else if (!ihit) begin
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
        if (drain_now) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
      if (wb_halt)        state_nxt = HALT;
      else if (freeze)    state_nxt = (state == DRAIN) ? DRAIN : DWAIT;
      else if (drain_now) state_nxt = DRAIN;
      else                state_nxt = RUN;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_ev;
  logic flush_ev;

  // Stalls and branch flushes are only counted while fetching normally (RUN/DWAIT).
  always_comb begin
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    if (!RST && (state == RUN || state == DWAIT)) begin
      stall_ev = freeze | (~(ex_branch_taken & ~drain_now) & (lu_haz | ~ihit));
      flush_ev = ~freeze & ex_branch_taken & ~drain_now;
    end
  end

  // Saturating counters; no events occur in HALT so they simply hold there.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + PERF_W'(1);
      if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule
